// File: rtl/fsm_arbiter_n.sv
// N-channel request/grant arbiter: fixed-priority or round-robin selection,
// optional per-ownership hold limit with timeout pulse and one-shot re-arbitration mask.
module fsm_arbiter_n #(
    parameter int unsigned N        = 4,
    parameter int unsigned MODE     = 0,
    parameter int unsigned MAX_HOLD = 0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy,
    output logic                 timeout
);

    localparam int unsigned IW       = $clog2(N);
    localparam int unsigned HW       = 8;
    localparam int unsigned HOLD_SAT = (MAX_HOLD == 0) ? 255 : MAX_HOLD;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01
    } state_t;

    state_t          state, state_d;
    logic [N-1:0]    gnt_d, mask, mask_d, eff_req;
    logic [IW-1:0]   gnt_id_d, ptr, ptr_d, win, win_next;
    logic            busy_d, timeout_d, win_valid;
    logic [HW-1:0]   hold_cnt, hold_d;

    // Winner selection; a timed-out channel is skipped only when someone else is asking.
    always_comb begin
        win       = '0;
        win_valid = 1'b0;
        eff_req   = req & ~mask;
        if (eff_req == '0) begin
            eff_req = req;
        end
        if (MODE == 0) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (eff_req[i]) begin
                    win       = IW'(i);
                    win_valid = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!win_valid && eff_req[IW'((int'(ptr) + i) % N)]) begin
                    win       = IW'((int'(ptr) + i) % N);
                    win_valid = 1'b1;
                end
            end
        end
        win_next = (win == IW'(N - 1)) ? '0 : win + IW'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
            mask     <= '0;
        end else begin
            state    <= state_d;
            gnt      <= gnt_d;
            gnt_id   <= gnt_id_d;
            busy     <= busy_d;
            timeout  <= timeout_d;
            ptr      <= ptr_d;
            hold_cnt <= hold_d;
            mask     <= mask_d;
        end
    end

    always_comb begin
        state_d   = state;
        gnt_d     = gnt;
        gnt_id_d  = gnt_id;
        busy_d    = busy;
        timeout_d = 1'b0;
        ptr_d     = ptr;
        hold_d    = hold_cnt;
        mask_d    = mask;
        case (state)
            IDLE: begin
                gnt_d    = '0;
                gnt_id_d = '0;
                busy_d   = 1'b0;
                hold_d   = '0;
                if (win_valid) begin
                    state_d  = GRANT;
                    gnt_d    = N'(1) << win;
                    gnt_id_d = win;
                    busy_d   = 1'b1;
                    hold_d   = HW'(1);
                    mask_d   = '0;
                    if (MODE != 0) begin
                        ptr_d = win_next;
                    end
                end
            end
            GRANT: begin
                if (!req[gnt_id]) begin
                    state_d  = IDLE;
                    gnt_d    = '0;
                    gnt_id_d = '0;
                    busy_d   = 1'b0;
                    hold_d   = '0;
                end else if (MAX_HOLD != 0 && hold_cnt == HW'(HOLD_SAT)) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    gnt_id_d  = '0;
                    busy_d    = 1'b0;
                    hold_d    = '0;
                    timeout_d = 1'b1;
                    if (MODE == 0) begin
                        mask_d = gnt;
                    end
                end else if (hold_cnt != HW'(HOLD_SAT)) begin
                    hold_d = hold_cnt + HW'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
                busy_d   = 1'b0;
                hold_d   = '0;
                mask_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_fsm_arbiter_n.sv
// Bench for fsm_arbiter_n: three configurations driven side by side and compared
// every cycle against an ownership-level reference model.
module tb_fsm_arbiter_n;

    localparam int NC = 3;
    localparam int N  = 4;
    localparam int CFG_MODE [NC] = '{0, 1, 1};
    localparam int CFG_HOLD [NC] = '{3, 0, 2};

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] reqv     [NC];
    logic [N-1:0] gntv     [NC];
    logic [1:0]   idv      [NC];
    logic         busyv    [NC];
    logic         tov      [NC];

    int tests = 0;
    int fails = 0;

    // Reference model: who owns the bus, for how long, and arbitration history.
    int m_owner [NC];
    int m_run   [NC];
    int m_ptr   [NC];
    int m_mask  [NC];
    bit m_to    [NC];
    int obs_run [NC];

    always #5 clock = ~clock;

    fsm_arbiter_n #(.N(N), .MODE(0), .MAX_HOLD(3)) u_fp3 (
        .clock(clock), .reset_n(reset_n), .req(reqv[0]), .gnt(gntv[0]),
        .gnt_id(idv[0]), .busy(busyv[0]), .timeout(tov[0]));
    fsm_arbiter_n #(.N(N), .MODE(1), .MAX_HOLD(0)) u_rr0 (
        .clock(clock), .reset_n(reset_n), .req(reqv[1]), .gnt(gntv[1]),
        .gnt_id(idv[1]), .busy(busyv[1]), .timeout(tov[1]));
    fsm_arbiter_n #(.N(N), .MODE(1), .MAX_HOLD(2)) u_rr2 (
        .clock(clock), .reset_n(reset_n), .req(reqv[2]), .gnt(gntv[2]),
        .gnt_id(idv[2]), .busy(busyv[2]), .timeout(tov[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < NC; k++) begin
            m_owner[k] = -1;
            m_run[k]   = 0;
            m_ptr[k]   = 0;
            m_mask[k]  = -1;
            m_to[k]    = 1'b0;
            obs_run[k] = 0;
        end
    endfunction

    function automatic void model_step(input int k, input logic [N-1:0] r);
        int w;
        bit others;
        m_to[k] = 1'b0;
        if (m_owner[k] < 0) begin
            if (r != '0) begin
                w = -1;
                if (CFG_MODE[k] == 0) begin
                    others = 1'b0;
                    for (int i = 0; i < N; i++)
                        if (r[i] && i != m_mask[k]) others = 1'b1;
                    for (int i = N - 1; i >= 0; i--)
                        if (r[i] && (!others || i != m_mask[k])) w = i;
                end else begin
                    for (int s = N - 1; s >= 0; s--)
                        if (r[(m_ptr[k] + s) % N]) w = (m_ptr[k] + s) % N;
                end
                m_owner[k] = w;
                m_run[k]   = 1;
                m_mask[k]  = -1;
                if (CFG_MODE[k] == 1) m_ptr[k] = (w + 1) % N;
            end
        end else if (!r[m_owner[k]]) begin
            m_owner[k] = -1;
        end else if (CFG_HOLD[k] > 0 && m_run[k] == CFG_HOLD[k]) begin
            if (CFG_MODE[k] == 0) m_mask[k] = m_owner[k];
            m_owner[k] = -1;
            m_to[k]    = 1'b1;
        end else begin
            m_run[k]++;
        end
    endfunction

    task automatic compare_all();
        for (int k = 0; k < NC; k++) begin
            logic [N-1:0] eg;
            eg = (m_owner[k] < 0) ? '0 : N'(1) << m_owner[k];
            check($sformatf("gnt[%0d]", k), 32'(gntv[k]), 32'(eg));
            check($sformatf("gnt_id[%0d]", k), 32'(idv[k]), (m_owner[k] < 0) ? 0 : m_owner[k]);
            check($sformatf("busy[%0d]", k), 32'(busyv[k]), 32'(m_owner[k] >= 0));
            check($sformatf("timeout[%0d]", k), 32'(tov[k]), 32'(m_to[k]));
            check($sformatf("onehot[%0d]", k), 32'($countones(gntv[k]) <= 1), 1);
            check($sformatf("busy_or[%0d]", k), 32'(busyv[k]), 32'(|gntv[k]));
            obs_run[k] = (gntv[k] != '0) ? obs_run[k] + 1 : 0;
            if (CFG_HOLD[k] > 0)
                check($sformatf("hold_run[%0d]", k), 32'(obs_run[k] <= CFG_HOLD[k]), 1);
        end
    endtask

    // One rising edge: model consumes the requests it sampled, then outputs are compared.
    task automatic cycle();
        @(posedge clock);
        #1;
        for (int k = 0; k < NC; k++) model_step(k, reqv[k]);
        compare_all();
    endtask

    task automatic set_req(input logic [N-1:0] r0, input logic [N-1:0] r1, input logic [N-1:0] r2);
        reqv[0] = r0;
        reqv[1] = r1;
        reqv[2] = r2;
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        set_req('0, '0, '0);
        model_reset();
        #12;
        compare_all();
        check("reset_gnt", 32'(gntv[0]), 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Fixed priority: 1010 grants 1, then 3 after one idle cycle.
        set_req(4'b1010, '0, '0);
        cycle();
        check("fp_first_gnt", 32'(gntv[0]), 32'h2);
        check("fp_first_id", 32'(idv[0]), 1);
        cycle();
        reqv[0] = 4'b1000;
        cycle();
        check("fp_gap", 32'(gntv[0]), 0);
        cycle();
        check("fp_second_gnt", 32'(gntv[0]), 32'h8);
        check("fp_second_id", 32'(idv[0]), 3);
        reqv[0] = '0;
        cycle();

        // Hold limit 3 with a competitor: timeout then the other channel.
        reqv[0] = 4'b0011;
        for (int c = 0; c < 3; c++) begin
            cycle();
            check("hold_gnt0", 32'(gntv[0]), 32'h1);
        end
        cycle();
        check("hold_to_gnt", 32'(gntv[0]), 0);
        check("hold_to_pulse", 32'(tov[0]), 1);
        cycle();
        check("hold_next_gnt", 32'(gntv[0]), 32'h2);
        check("hold_to_clear", 32'(tov[0]), 0);
        reqv[0] = '0;
        cycle();

        // Sole requester regains the bus after its own timeout.
        reqv[0] = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            cycle();
            check("sole_gnt0", 32'(gntv[0]), 32'h1);
        end
        cycle();
        check("sole_to", 32'(tov[0]), 1);
        cycle();
        check("sole_regain", 32'(gntv[0]), 32'h1);
        reqv[0] = '0;
        cycle();

        // Round-robin rotation 0,1,2,3,0 from a fresh pointer.
        pulse_reset();
        set_req('0, 4'b1111, '0);
        for (int g = 0; g < 5; g++) begin
            cycle();
            check("rr_order", 32'(gntv[1]), 32'(1 << (g % N)));
            cycle();
            reqv[1] = 4'b1111 & ~(4'(1) << (g % N));
            cycle();
            check("rr_gap", 32'(gntv[1]), 0);
            reqv[1] = 4'b1111;
        end
        reqv[1] = '0;
        cycle();

        // Asynchronous reset mid-grant restores the round-robin pointer.
        set_req(4'b0100, 4'b0100, 4'b0100);
        cycle();
        check("pre_rst_gnt", 32'(gntv[1]), 32'h4);
        pulse_reset();
        check("rst_async_gnt", 32'(gntv[1]), 0);
        check("rst_async_busy", 32'(busyv[1]), 0);
        set_req(4'b1100, 4'b1100, 4'b1100);
        cycle();
        check("rst_ptr_gnt", 32'(gntv[1]), 32'h4);

        // Random traffic with sticky requests so ownerships and timeouts occur.
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < NC; k++)
                if ($urandom_range(3) == 0) reqv[k] = 4'($urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
